// File: rtl/traffic_pkg.sv
// traffic_pkg: shared mode/phase encodings and light bit positions for the phase controller
package traffic_pkg;
  typedef enum logic [1:0] {M_AUTO = 2'd0, M_MANUAL = 2'd1, M_CONFIG = 2'd2, M_FLASH = 2'd3} mode_e;
  typedef enum logic [1:0] {GREEN = 2'd0, YELLOW = 2'd1, ALLRED = 2'd2} phase_e;
  localparam int RED = 2;
  localparam int YEL = 1;
  localparam int GRN = 0;
endpackage

// File: rtl/traffic_phase_timer.sv
// traffic_phase_timer: loadable down-counter paced by tick; done marks the final tick of a phase
module traffic_phase_timer #(
  parameter int TIME_W = 7,
  parameter int RST_VAL = 30
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              tick,
  input  logic              load,
  input  logic [TIME_W-1:0] load_val,
  output logic [TIME_W-1:0] remaining,
  output logic              done
);
  assign done = tick && remaining == TIME_W'(1);
  always_ff @(posedge clk or posedge reset)
    if (reset) remaining <= TIME_W'(RST_VAL);
    else if (load) remaining <= load_val;
    else if (tick && remaining > TIME_W'(1)) remaining <= remaining - 1'b1;
endmodule

// File: rtl/traffic_phase_ctrl.sv
// traffic_phase_ctrl: multi-approach traffic-light sequencer with auto, manual, config and flash modes
module traffic_phase_ctrl
  import traffic_pkg::*;
#(
  parameter int NUM_DIR = 2,
  parameter int TIME_W = 7,
  parameter int GREEN_DEF = 30,
  parameter int YELLOW_DEF = 3,
  parameter int ALL_RED_T = 1,
  parameter int TIME_MIN = 1,
  parameter int TIME_MAX = 99
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           tick,
  input  logic                           btn_mode,
  input  logic                           btn_config,
  input  logic                           btn_next,
  input  logic                           btn_inc,
  input  logic                           btn_dec,
  input  logic                           btn_confirm,
  output logic [3*NUM_DIR-1:0]           lights,
  output logic [$clog2(NUM_DIR)-1:0]     active_dir,
  output logic [TIME_W-1:0]              remaining,
  output logic [1:0]                     mode,
  output logic [$clog2(NUM_DIR+1)-1:0]   cfg_sel,
  output logic [TIME_W-1:0]              cfg_value
);
  localparam int DW = $clog2(NUM_DIR);
  localparam int SW = $clog2(NUM_DIR + 1);
  localparam logic [TIME_W-1:0] T_MIN = TIME_W'(TIME_MIN);
  localparam logic [TIME_W-1:0] T_MAX = TIME_W'(TIME_MAX);
  localparam logic [TIME_W-1:0] T_AR = TIME_W'(ALL_RED_T);
  localparam logic [DW-1:0] LAST = DW'(NUM_DIR - 1);
  mode_e mode_q, mode_d;
  phase_e phase_q, phase_d;
  logic [DW-1:0] dir_q, dir_d, dir_nx;
  logic [SW-1:0] sel_d;
  logic [TIME_W-1:0] val_d, yellow_q, yellow_d, load_val;
  logic [TIME_W-1:0] green_q [NUM_DIR];
  logic [TIME_W-1:0] green_d [NUM_DIR];
  logic flash_q, flash_d, load, done, drop;
  logic p_cfg, p_mode, p_conf, p_next, p_inc, p_dec;
  // one-hot winner of the button priority chain
  assign p_cfg = btn_config;
  assign p_mode = btn_mode & ~btn_config;
  assign p_conf = btn_confirm & ~btn_config & ~btn_mode;
  assign p_next = btn_next & ~(btn_config | btn_mode | btn_confirm);
  assign p_inc = btn_inc & ~(btn_config | btn_mode | btn_confirm | btn_next);
  assign p_dec = btn_dec & ~(btn_config | btn_mode | btn_confirm | btn_next | btn_inc);
  assign drop = (p_cfg && (mode_q == M_AUTO || mode_q == M_CONFIG)) || (p_mode && mode_q != M_CONFIG) ||
                (p_next && mode_q == M_MANUAL && phase_q == GREEN);
  assign dir_nx = dir_q == LAST ? '0 : dir_q + 1'b1;
  assign mode = mode_q;
  assign active_dir = dir_q;
  function automatic logic [TIME_W-1:0] stored(input logic [SW-1:0] s);
    stored = yellow_q;
    for (int i = 0; i < NUM_DIR; i++) if (s == SW'(i)) stored = green_q[i];
  endfunction
  traffic_phase_timer #(.TIME_W(TIME_W), .RST_VAL(GREEN_DEF)) u_timer (
    .clk(clk), .reset(reset), .tick(tick & ~drop), .load(load), .load_val(load_val),
    .remaining(remaining), .done(done)
  );
  always_comb begin
    mode_d = mode_q;
    phase_d = phase_q;
    dir_d = dir_q;
    flash_d = flash_q;
    sel_d = cfg_sel;
    val_d = cfg_value;
    yellow_d = yellow_q;
    green_d = green_q;
    load = 1'b0;
    load_val = '0;
    if (p_cfg && mode_q == M_AUTO) begin
      mode_d = M_CONFIG;
      sel_d = '0;
      val_d = green_q[0];
      load = 1'b1;
    end else if (p_cfg && mode_q == M_CONFIG) begin
      mode_d = M_AUTO;
      phase_d = GREEN;
      dir_d = '0;
      load = 1'b1;
      load_val = green_q[0];
    end else if (p_mode && mode_q == M_AUTO) begin
      mode_d = M_MANUAL;
      load = phase_q == GREEN;
    end else if (p_mode && mode_q == M_MANUAL) begin
      mode_d = M_FLASH;
      flash_d = 1'b1;
      load = 1'b1;
    end else if (p_mode && mode_q == M_FLASH) begin
      mode_d = M_AUTO;
      load = 1'b1;
      if (ALL_RED_T == 0) begin
        phase_d = GREEN;
        dir_d = '0;
        load_val = green_q[0];
      end else begin
        phase_d = ALLRED;
        dir_d = LAST;
        load_val = T_AR;
      end
    end else if (mode_q == M_CONFIG) begin
      if (p_conf) begin
        for (int i = 0; i < NUM_DIR; i++) if (cfg_sel == SW'(i)) green_d[i] = cfg_value;
        if (cfg_sel == SW'(NUM_DIR)) yellow_d = cfg_value;
      end else if (p_next) begin
        sel_d = cfg_sel == SW'(NUM_DIR) ? '0 : cfg_sel + 1'b1;
        val_d = stored(sel_d);
      end else if (p_inc) val_d = cfg_value < T_MAX ? cfg_value + 1'b1 : T_MAX;
      else if (p_dec) val_d = cfg_value > T_MIN ? cfg_value - 1'b1 : T_MIN;
    end else if (p_next && mode_q == M_MANUAL && phase_q == GREEN) begin
      phase_d = YELLOW;
      load = 1'b1;
      load_val = yellow_q;
    end else if (mode_q == M_FLASH) flash_d = flash_q ^ tick;
    else if (done) begin
      load = 1'b1;
      if (phase_q == GREEN) begin
        phase_d = YELLOW;
        load_val = yellow_q;
      end else if (phase_q == YELLOW && ALL_RED_T != 0) begin
        phase_d = ALLRED;
        load_val = T_AR;
      end else begin
        phase_d = GREEN;
        dir_d = dir_nx;
        load_val = mode_q == M_MANUAL ? '0 : green_q[dir_nx];
      end
    end
  end
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      mode_q <= M_AUTO;
      phase_q <= GREEN;
      dir_q <= '0;
      flash_q <= 1'b0;
      cfg_sel <= '0;
      cfg_value <= '0;
      yellow_q <= TIME_W'(YELLOW_DEF);
      for (int i = 0; i < NUM_DIR; i++) green_q[i] <= TIME_W'(GREEN_DEF);
    end else begin
      mode_q <= mode_d;
      phase_q <= phase_d;
      dir_q <= dir_d;
      flash_q <= flash_d;
      cfg_sel <= sel_d;
      cfg_value <= val_d;
      yellow_q <= yellow_d;
      green_q <= green_d;
    end
  always_comb begin
    lights = '0;
    for (int i = 0; i < NUM_DIR; i++)
      if (mode_q == M_FLASH) lights[3*i+YEL] = flash_q;
      else if (mode_q == M_CONFIG || phase_q == ALLRED || dir_q != DW'(i)) lights[3*i+RED] = 1'b1;
      else if (phase_q == GREEN) lights[3*i+GRN] = 1'b1;
      else lights[3*i+YEL] = 1'b1;
  end
endmodule

// File: tb/tb_traffic_phase_ctrl.sv
// tb_traffic_phase_ctrl: directed and random stimulus checked against a behavioural light-sequence model
module tb_traffic_phase_ctrl;
  localparam int ND = 2, TW = 7, GD = 5, YD = 2, ART = 1, TMIN = 1, TMAX = 99;
  localparam logic [5:0] B_CFG = 6'b100000, B_MODE = 6'b010000, B_CONF = 6'b001000;
  localparam logic [5:0] B_NEXT = 6'b000100, B_INC = 6'b000010, B_DEC = 6'b000001;
  logic clk = 1'b0, reset = 1'b1, tick = 1'b0;
  logic btn_mode = 1'b0, btn_config = 1'b0, btn_next = 1'b0, btn_inc = 1'b0, btn_dec = 1'b0, btn_confirm = 1'b0;
  logic [3*ND-1:0] lights;
  logic [0:0] active_dir;
  logic [TW-1:0] remaining, cfg_value;
  logic [1:0] mode, cfg_sel;
  int errors = 0, checks = 0;
  int m_mode, m_ph, m_dir, m_rem, m_yel, m_sel, m_val;
  int m_green [ND];
  bit m_fl;
  logic [5:0] rb;
  int exp_rem [16] = '{4, 3, 2, 1, 2, 1, 1, 5, 4, 3, 2, 1, 2, 1, 1, 5};
  int exp_dir [16] = '{0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 0};
  logic [5:0] exp_lt [16] = '{6'b100001, 6'b100001, 6'b100001, 6'b100001, 6'b100010, 6'b100010, 6'b100100,
                              6'b001100, 6'b001100, 6'b001100, 6'b001100, 6'b001100, 6'b010100, 6'b010100,
                              6'b100100, 6'b100001};
  int exp_sel [3] = '{1, 2, 0};

  traffic_phase_ctrl #(.NUM_DIR(ND), .TIME_W(TW), .GREEN_DEF(GD), .YELLOW_DEF(YD), .ALL_RED_T(ART),
                       .TIME_MIN(TMIN), .TIME_MAX(TMAX)) dut (
    .clk(clk), .reset(reset), .tick(tick), .btn_mode(btn_mode), .btn_config(btn_config), .btn_next(btn_next),
    .btn_inc(btn_inc), .btn_dec(btn_dec), .btn_confirm(btn_confirm), .lights(lights), .active_dir(active_dir),
    .remaining(remaining), .mode(mode), .cfg_sel(cfg_sel), .cfg_value(cfg_value)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // phase length on entry: green is untimed in manual mode
  function automatic int dur(input int ph, input int d);
    return ph == 0 ? (m_mode == 1 ? 0 : m_green[d]) : ph == 1 ? m_yel : ART;
  endfunction

  task automatic go(input int ph, input int d);
    m_ph = ph;
    m_dir = d;
    m_rem = dur(ph, d);
  endtask

  task automatic m_reset();
    m_mode = 0; m_yel = YD; m_sel = 0; m_val = 0; m_fl = 0;
    foreach (m_green[i]) m_green[i] = GD;
    go(0, 0);
  endtask

  function automatic int stored(input int s);
    return s == ND ? m_yel : m_green[s];
  endfunction

  task automatic model(input logic [5:0] b, input bit tk);
    bit hit = 0;
    case (m_mode)
      0: if (b[5]) begin m_mode = 2; m_sel = 0; m_val = m_green[0]; m_rem = 0; hit = 1; end
         else if (b[4]) begin m_mode = 1; if (m_ph == 0) m_rem = 0; hit = 1; end
      1: if (b[5]) ;
         else if (b[4]) begin m_mode = 3; m_fl = 1; m_rem = 0; hit = 1; end
         else if (!b[3] && b[2] && m_ph == 0) begin go(1, m_dir); hit = 1; end
      2: if (b[5]) begin m_mode = 0; go(0, 0); hit = 1; end
         else if (b[4]) ;
         else if (b[3]) begin if (m_sel == ND) m_yel = m_val; else m_green[m_sel] = m_val; end
         else if (b[2]) begin m_sel = (m_sel + 1) % (ND + 1); m_val = stored(m_sel); end
         else if (b[1]) m_val = m_val < TMAX ? m_val + 1 : TMAX;
         else if (b[0]) m_val = m_val > TMIN ? m_val - 1 : TMIN;
      default: if (b[4] && !b[5]) begin m_mode = 0; if (ART == 0) go(0, 0); else go(2, ND - 1); hit = 1; end
               else if (tk) m_fl = !m_fl;
    endcase
    if (!hit && tk && m_mode < 2) begin
      if (m_rem > 1) m_rem--;
      else if (m_rem == 1) begin
        if (m_ph == 0) go(1, m_dir);
        else if (m_ph == 1 && ART > 0) go(2, m_dir);
        else go(0, (m_dir + 1) % ND);
      end
    end
  endtask

  function automatic logic [5:0] exp_lights();
    logic [5:0] l = '0;
    for (int d = 0; d < ND; d++)
      l[3*d +: 3] = m_mode == 3 ? {1'b0, m_fl, 1'b0} :
                    (m_mode == 2 || m_ph == 2 || d != m_dir) ? 3'b100 : m_ph == 0 ? 3'b001 : 3'b010;
    return l;
  endfunction

  task automatic compare();
    chk("mode", mode, m_mode);
    chk("lights", lights, exp_lights());
    chk("active_dir", active_dir, m_dir);
    chk("remaining", remaining, m_rem);
    chk("cfg_sel", cfg_sel, m_sel);
    chk("cfg_value", cfg_value, m_val);
  endtask

  task automatic step(input logic [5:0] b, input bit tk);
    {btn_config, btn_mode, btn_confirm, btn_next, btn_inc, btn_dec} = b;
    tick = tk;
    model(b, tk);
    @(posedge clk);
    #1;
    {btn_config, btn_mode, btn_confirm, btn_next, btn_inc, btn_dec} = '0;
    tick = 1'b0;
    compare();
  endtask

  task automatic ticks(input int n);
    repeat (n) begin
      repeat (3) step('0, 1'b0);
      step('0, 1'b1);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    m_reset();
    @(posedge clk);
    #1;
    compare();
    reset = 1'b0;
    @(posedge clk);
    #1;
    compare();
  endtask

  task automatic chk_reset_vals();
    chk("rst_mode", mode, 0);
    chk("rst_dir", active_dir, 0);
    chk("rst_rem", remaining, GD);
    chk("rst_lights", lights, 6'b100001);
    chk("rst_sel", cfg_sel, 0);
    chk("rst_val", cfg_value, 0);
  endtask

  initial begin
    do_reset();
    chk_reset_vals();
    for (int k = 0; k < 16; k++) begin
      ticks(1);
      chk("seq_rem", remaining, exp_rem[k]);
      chk("seq_dir", active_dir, exp_dir[k]);
      chk("seq_lights", lights, exp_lt[k]);
    end
    ticks(1);
    chk("seq17_rem", remaining, 4);
    step(B_CFG, 1'b0);
    chk("cfg_enter_mode", mode, 2);
    chk("cfg_enter_val", cfg_value, GD);
    chk("cfg_enter_rem", remaining, 0);
    chk("cfg_lights", lights, 6'b100100);
    repeat (2) step(B_INC, 1'b0);
    chk("cfg_inc", cfg_value, 7);
    step(B_CONF, 1'b0);
    step(B_NEXT, 1'b0);
    chk("cfg_next_sel", cfg_sel, 1);
    chk("cfg_next_val", cfg_value, GD);
    step(B_DEC, 1'b0);
    chk("cfg_dec", cfg_value, 4);
    step(B_CFG, 1'b0);
    chk("cfg_exit_mode", mode, 0);
    chk("cfg_exit_rem", remaining, 7);
    chk("cfg_exit_lights", lights, 6'b100001);
    step(B_CFG, 1'b0);
    step(B_NEXT, 1'b0);
    chk("green1_kept", cfg_value, GD);
    repeat (200) step(B_INC, 1'b0);
    chk("sat_max", cfg_value, TMAX);
    repeat (200) step(B_DEC, 1'b0);
    chk("sat_min", cfg_value, TMIN);
    step(B_DEC, 1'b0);
    chk("sat_min_hold", cfg_value, TMIN);
    step(B_CFG, 1'b0);
    step(B_CFG, 1'b0);
    chk("sel_start", cfg_sel, 0);
    for (int k = 0; k < 3; k++) begin
      step(B_NEXT, 1'b0);
      chk("sel_wrap", cfg_sel, exp_sel[k]);
    end
    step(B_CFG, 1'b0);
    do_reset();
    step(B_MODE, 1'b0);
    chk("man_mode", mode, 1);
    ticks(20);
    chk("man_hold_rem", remaining, 0);
    chk("man_hold_lights", lights, 6'b100001);
    step(B_NEXT, 1'b0);
    chk("man_yel_rem", remaining, YD);
    chk("man_yel_lights", lights, 6'b100010);
    step(B_NEXT, 1'b1);
    chk("man_next_ign", remaining, 1);
    chk("man_next_ign_lt", lights, 6'b100010);
    ticks(1);
    chk("man_allred", lights, 6'b100100);
    ticks(1);
    chk("man_green1", lights, 6'b001100);
    chk("man_green1_rem", remaining, 0);
    ticks(5);
    chk("man_green1_hold", lights, 6'b001100);
    step(B_MODE, 1'b0);
    chk("fl_mode", mode, 3);
    chk("fl_on", lights, 6'b010010);
    ticks(1);
    chk("fl_off", lights, 6'b000000);
    ticks(1);
    chk("fl_on2", lights, 6'b010010);
    step(B_MODE, 1'b0);
    chk("fl_exit_lights", lights, 6'b100100);
    chk("fl_exit_dir", active_dir, ND - 1);
    chk("fl_exit_rem", remaining, ART);
    ticks(1);
    chk("fl_green0", lights, 6'b100001);
    chk("fl_green0_rem", remaining, GD);
    step(B_CFG | B_INC, 1'b0);
    chk("prio_mode", mode, 2);
    chk("prio_val", cfg_value, GD);
    step(B_CFG, 1'b0);
    ticks(6);
    chk("pre_rst_yel", lights, 6'b100010);
    do_reset();
    chk_reset_vals();
    for (int c = 0; c < 4000; c++) begin
      for (int j = 0; j < 6; j++) rb[j] = ($urandom_range(11) == 0);
      step(rb, c % 4 == 3);
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
